alu_seq: RTL

Parametrised, handshaked successor to the team's combinational 4-bit ALU. It keeps the same 4-bit opcode map (shift / arithmetic / logical / compare groups) and generalises the operand width. Results and Z/C/V/N flags are registered behind a valid/ready output stage, and shifts run iteratively, one bit per cycle. It sits between the `ui_in` operand decode and the `uo_out` LED/result drivers of the top-level wrapper.

---
 rtl/alu_seq.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU with registered result/Z/C/V/N and bit-serial shifts.
// Optional accumulator operand source enabled by defining ALU_ACC_EN.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ALU_ACC_EN
  input  logic             use_acc,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             c,
  output logic             v,
  output logic             n
);

  localparam int SHAMT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   work_r, work_s;
  logic [SHAMT_W-1:0] cnt_r, cnt_s;
  logic [1:0]         sop_r, sop_s;
  logic [WIDTH-1:0]   result_r, result_s;
  logic               z_r, z_s, c_r, c_s, v_r, v_s, n_r, n_s;
  logic               out_valid_r, out_valid_s;
  logic [WIDTH-1:0]   acc_r, acc_s;
  logic [WIDTH-1:0]   b_eff_s, shifted_s;
  logic [WIDTH+1:0]   eval_s;
  logic [SHAMT_W-1:0] amt_s;
  logic               accept_s, retire_s;

  // One step of the selected shift/rotate on the working register.
  function automatic logic [WIDTH-1:0] shift_one(input logic [1:0] sop, input logic [WIDTH-1:0] val);
    logic [WIDTH-1:0] r;
    case (sop)
      2'b00:   r = {val[WIDTH-2:0], 1'b0};
      2'b01:   r = {val[WIDTH-2:0], val[WIDTH-1]};
      2'b10:   r = {1'b0, val[WIDTH-1:1]};
      2'b11:   r = {val[WIDTH-1], val[WIDTH-1:1]};
      default: r = val;
    endcase
    return r;
  endfunction

  // Single-cycle evaluation; returns {result, carry, overflow}. Zero-amount shifts pass y through.
  function automatic logic [WIDTH+1:0] alu_eval(input logic [3:0] op, input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res, opd;
    logic             cy, ov, cin;
    res = {WIDTH{1'b0}};
    cy  = 1'b0;
    ov  = 1'b0;
    opd = op[0] ? {{(WIDTH-1){1'b0}}, 1'b1} : y;
    case (op[3:2])
      2'b00: res = y;
      2'b01: begin
        // SUB/DEC add the ones' complement plus one, so carry means no borrow
        if (op[1]) begin
          opd = ~opd;
        end else begin
          opd = opd;
        end
        sum = {1'b0, x} + {1'b0, opd} + {{WIDTH{1'b0}}, op[1]};
        res = sum[WIDTH-1:0];
        cy  = sum[WIDTH];
        cin = x[WIDTH-1] ^ opd[WIDTH-1] ^ res[WIDTH-1];
        ov  = cin ^ cy;
      end
      2'b10: begin
        case (op[1:0])
          2'b00:   res = x & y;
          2'b01:   res = x | y;
          2'b10:   res = x ^ y;
          2'b11:   res = ~(x | y);
          default: res = {WIDTH{1'b0}};
        endcase
      end
      2'b11: begin
        case (op[1:0])
          2'b00:   res = {{(WIDTH-1){1'b0}}, (x == y)};
          2'b01:   res = {{(WIDTH-1){1'b0}}, (x != y)};
          2'b10:   res = {{(WIDTH-1){1'b0}}, ($signed(x) > $signed(y))};
          2'b11:   res = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
          default: res = {WIDTH{1'b0}};
        endcase
      end
      default: res = {WIDTH{1'b0}};
    endcase
    return {res, cy, ov};
  endfunction

`ifdef ALU_ACC_EN
  assign b_eff_s = use_acc ? acc_r : b;
`else
  assign b_eff_s = b;
`endif

  assign amt_s     = a[SHAMT_W-1:0];
  assign in_ready  = (state_r == S_IDLE) || ((state_r == S_HOLD) && out_ready);
  assign accept_s  = in_valid && in_ready;
  assign retire_s  = out_valid_r && out_ready;
  assign shifted_s = shift_one(sop_r, work_r);
  assign eval_s    = alu_eval(opcode, a, b_eff_s);

  // Next-state and datapath decode.
  always_comb begin
    state_s     = state_r;
    work_s      = work_r;
    cnt_s       = cnt_r;
    sop_s       = sop_r;
    result_s    = result_r;
    z_s         = z_r;
    c_s         = c_r;
    v_s         = v_r;
    n_s         = n_r;
    out_valid_s = out_valid_r;
    acc_s       = acc_r;
    case (state_r)
      S_IDLE, S_HOLD: begin
        if (retire_s) begin
          state_s     = S_IDLE;
          out_valid_s = 1'b0;
          acc_s       = result_r;
        end else begin
          acc_s = acc_r;
        end
        // An accept in HOLD is only possible alongside a retire, so it restarts as from IDLE
        if (accept_s) begin
          if ((opcode[3:2] == 2'b00) && (amt_s != {SHAMT_W{1'b0}})) begin
            state_s     = S_SHIFT;
            work_s      = b_eff_s;
            cnt_s       = amt_s;
            sop_s       = opcode[1:0];
            out_valid_s = 1'b0;
          end else begin
            state_s     = S_HOLD;
            result_s    = eval_s[WIDTH+1:2];
            z_s         = (eval_s[WIDTH+1:2] == {WIDTH{1'b0}});
            c_s         = eval_s[1];
            v_s         = eval_s[0];
            n_s         = eval_s[WIDTH+1];
            out_valid_s = 1'b1;
          end
        end else begin
          work_s = work_r;
        end
      end
      S_SHIFT: begin
        work_s = shifted_s;
        cnt_s  = cnt_r - {{(SHAMT_W-1){1'b0}}, 1'b1};
        if (cnt_r == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
          state_s     = S_HOLD;
          result_s    = shifted_s;
          z_s         = (shifted_s == {WIDTH{1'b0}});
          c_s         = 1'b0;
          v_s         = 1'b0;
          n_s         = shifted_s[WIDTH-1];
          out_valid_s = 1'b1;
        end else begin
          state_s = S_SHIFT;
        end
      end
      default: begin
        state_s     = S_IDLE;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      work_r      <= {WIDTH{1'b0}};
      cnt_r       <= {SHAMT_W{1'b0}};
      sop_r       <= 2'b00;
      result_r    <= {WIDTH{1'b0}};
      z_r         <= 1'b0;
      c_r         <= 1'b0;
      v_r         <= 1'b0;
      n_r         <= 1'b0;
      out_valid_r <= 1'b0;
      acc_r       <= {WIDTH{1'b0}};
    end else begin
      state_r     <= state_s;
      work_r      <= work_s;
      cnt_r       <= cnt_s;
      sop_r       <= sop_s;
      result_r    <= result_s;
      z_r         <= z_s;
      c_r         <= c_s;
      v_r         <= v_s;
      n_r         <= n_s;
      out_valid_r <= out_valid_s;
      acc_r       <= acc_s;
    end
  end

`ifndef ALU_ACC_EN
  logic unused_acc_s;
  assign unused_acc_s = ^acc_r;
`endif

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign z         = z_r;
  assign c         = c_r;
  assign v         = v_r;
  assign n         = n_r;

endmodule
